// File: rtl/result_readout.sv
// Drains a contiguous address range out of the single-port result RAM (1-cycle read latency)
// through a 2-entry skid FIFO onto a valid/ready stream, tagging the final word with m_last.
module result_readout #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W:0]           remaining_q, remaining_d;
    logic [ADDR_W:0]           left_out_q, left_out_d;
    logic                      inflight_q, inflight_d;
    logic [1:0][DATA_W-1:0]    fifo_q, fifo_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;

    logic       accept, issue, push, pop;
    logic [2:0] occupancy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_words == '0) ? DONE : READ;
            READ:    if (remaining_d == '0) state_d = DRAIN;
            // left_out reaching zero means the last word just handshook, so the
            // FIFO and the read pipe are necessarily empty as well.
            DRAIN:   if (left_out_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        m_valid  = (count_q != 2'd0);
        m_data   = m_valid ? fifo_q[rd_ptr_q] : '0;
        m_last   = m_valid && (left_out_q == (ADDR_W+1)'(1));
        ram_en   = issue;
        ram_we   = 1'b0;
        ram_addr = addr_q;
    end

    // Issue only when the slot is guaranteed: a word popped this cycle frees space.
    always_comb begin
        pop       = (count_q != 2'd0) && m_ready;
        push      = inflight_q;
        accept    = (state_q == IDLE) && start;
        occupancy = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue     = (state_q == READ) && (remaining_q != '0) && (occupancy < 3'd2);
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        left_out_d  = left_out_q;
        inflight_d  = issue;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        if (push) fifo_d[wr_ptr_q] = ram_dout;
        if (accept) begin
            addr_d      = base_addr;
            remaining_d = num_words;
            left_out_d  = num_words;
        end else begin
            if (issue) begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - (ADDR_W+1)'(1);
            end
            if (pop) left_out_d = left_out_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            left_out_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            left_out_q  <= left_out_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule
